// File: rtl/bcd_calc_pkg.sv
// rtl/bcd_calc_pkg.sv - key codes, opcodes and entry FSM states for the BCD calculator front end
package bcd_calc_pkg;

    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_EQ   = 4'hC;
    localparam logic [3:0] KEY_NEG  = 4'hD;
    localparam logic [3:0] KEY_CLR  = 4'hE;
    localparam logic [3:0] KEY_NONE = 4'hF;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;

    typedef enum logic [2:0] {
        ENTRY1,
        LOAD1,
        HOLD1,
        ENTRY2,
        LOAD2,
        HOLD2,
        RESULT
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_buf.sv
// rtl/bcd_digit_buf.sv - two-digit BCD entry shift register with sign, digit count and saturation
module bcd_digit_buf (
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr,
    input  logic       load_first,
    input  logic       neg_first,
    input  logic       shift_en,
    input  logic       sign_toggle,
    input  logic [3:0] digit,
    output logic [7:0] digits_d,
    output logic       sign_d,
    output logic [7:0] digits_q,
    output logic       sign_q,
    output logic [1:0] count_q
);

    logic [1:0] count_d;

    always_comb begin
        digits_d = digits_q;
        sign_d   = sign_q;
        count_d  = count_q;
        if (clr) begin
            digits_d = 8'h00;
            sign_d   = 1'b0;
            count_d  = 2'd0;
        end else if (load_first) begin
            digits_d = {4'h0, digit};
            sign_d   = 1'b0;
            count_d  = 2'd1;
        end else if (neg_first) begin
            digits_d = 8'h00;
            sign_d   = 1'b1;
            count_d  = 2'd0;
        end else begin
            // a third digit is dropped rather than pushing the tens digit out
            if (shift_en && count_q != 2'd2) begin
                digits_d = {digits_q[3:0], digit};
                count_d  = count_q + 2'd1;
            end
            if (sign_toggle)
                sign_d = ~sign_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            digits_q <= 8'h00;
            sign_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            digits_q <= digits_d;
            sign_q   <= sign_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bcd_entry_ctrl.sv
// rtl/bcd_entry_ctrl.sv - keypad entry FSM feeding sign-magnitude BCD operands to the BCD ALU
module bcd_entry_ctrl
    import bcd_calc_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [8:0] op,
    output logic [2:0] opcode,
    output logic       assign_op1,
    output logic       assign_op2,
    output logic       alu_en,
    output logic [8:0] entry_disp,
    output logic       busy
);

    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    entry_state_t state, next_state;
    logic [CW-1:0] hold_cnt;
    logic          hold_done;

    logic key_dig, key_add_sub, key_eq, key_neg, key_clr;
    logic buf_clr, buf_first, buf_neg_first, buf_shift, buf_toggle;
    logic [7:0] digits_d, digits_q;
    logic       sign_d, sign_q;
    logic [1:0] count_q;
    logic [8:0] load_word, op_d, disp_d;
    logic [2:0] opcode_d;
    logic       a1_d, a2_d, alu_en_d, busy_d;

    assign key_dig     = key_valid && is_digit(key_code);
    assign key_add_sub = key_valid && (key_code == KEY_ADD || key_code == KEY_SUB);
    assign key_eq      = key_valid && key_code == KEY_EQ;
    assign key_neg     = key_valid && key_code == KEY_NEG;
    assign key_clr     = key_valid && key_code == KEY_CLR;
    assign hold_done   = hold_cnt == CW'(HOLD_CYCLES - 1);

    // an operand with no digits is always presented as +00
    assign load_word = (count_q == 2'd0) ? 9'h000 : {sign_q, digits_q};

    bcd_digit_buf u_digit_buf (
        .clk         (clk),
        .nrst        (nrst),
        .clr         (buf_clr),
        .load_first  (buf_first),
        .neg_first   (buf_neg_first),
        .shift_en    (buf_shift),
        .sign_toggle (buf_toggle),
        .digit       (key_code),
        .digits_d    (digits_d),
        .sign_d      (sign_d),
        .digits_q    (digits_q),
        .sign_q      (sign_q),
        .count_q     (count_q)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= ENTRY1;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            hold_cnt <= ((state == HOLD1 || state == HOLD2) && next_state == state)
                        ? hold_cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        next_state = state;
        if (key_clr) begin
            next_state = ENTRY1;
        end else begin
            case (state)
                ENTRY1:  if (key_add_sub) next_state = LOAD1;
                LOAD1:   next_state = HOLD1;
                HOLD1:   if (hold_done) next_state = ENTRY2;
                ENTRY2:  if (key_eq) next_state = LOAD2;
                LOAD2:   next_state = HOLD2;
                HOLD2:   if (hold_done) next_state = RESULT;
                RESULT:  if (key_dig || key_neg) next_state = ENTRY1;
                default: next_state = ENTRY1;
            endcase
        end
    end

    always_comb begin
        buf_clr       = 1'b0;
        buf_first     = 1'b0;
        buf_neg_first = 1'b0;
        buf_shift     = 1'b0;
        buf_toggle    = 1'b0;
        op_d          = op;
        opcode_d      = opcode;
        if (key_clr) begin
            buf_clr  = 1'b1;
            op_d     = 9'h000;
            opcode_d = OP_NONE;
        end else begin
            case (state)
                ENTRY1: begin
                    buf_shift  = key_dig;
                    buf_toggle = key_neg;
                    if (key_add_sub) begin
                        op_d     = load_word;
                        opcode_d = (key_code == KEY_ADD) ? OP_ADD : OP_SUB;
                    end
                end
                ENTRY2: begin
                    buf_shift  = key_dig;
                    buf_toggle = key_neg;
                    // operator re-selection only before any operand-2 entry
                    if (key_add_sub && count_q == 2'd0 && !sign_q)
                        opcode_d = (key_code == KEY_ADD) ? OP_ADD : OP_SUB;
                    if (key_eq)
                        op_d = load_word;
                end
                HOLD1, HOLD2: buf_clr = hold_done;
                RESULT: begin
                    buf_first     = key_dig;
                    buf_neg_first = key_neg;
                end
                default: ;
            endcase
        end
        a1_d     = next_state == LOAD1;
        a2_d     = next_state == LOAD2;
        alu_en_d = next_state == RESULT;
        busy_d   = next_state == LOAD1 || next_state == HOLD1 ||
                   next_state == LOAD2 || next_state == HOLD2;
        disp_d   = (next_state == ENTRY1 || next_state == ENTRY2) ? {sign_d, digits_d} : 9'h000;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op         <= 9'h000;
            opcode     <= OP_NONE;
            assign_op1 <= 1'b0;
            assign_op2 <= 1'b0;
            alu_en     <= 1'b0;
            entry_disp <= 9'h000;
            busy       <= 1'b0;
        end else begin
            op         <= op_d;
            opcode     <= opcode_d;
            assign_op1 <= a1_d;
            assign_op2 <= a2_d;
            alu_en     <= alu_en_d;
            entry_disp <= disp_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// tb/tb_bcd_entry_ctrl.sv - directed and random key sequences against a calculator-level model
module tb_bcd_entry_ctrl;
    import bcd_calc_pkg::*;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = KEY_NONE;
    logic [8:0] op, entry_disp;
    logic [2:0] opcode;
    logic       assign_op1, assign_op2, alu_en, busy;

    int total = 0;
    int bad = 0;

    // calculator-level model: operand stage, decimal value, digit count, busy countdown
    int         stage;
    int         val;
    int         nd;
    bit         sg;
    int         busy_left;
    logic [8:0] m_op;
    logic [2:0] m_opc;
    logic       m_a1, m_a2, m_alu;

    bcd_entry_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .op         (op),
        .opcode     (opcode),
        .assign_op1 (assign_op1),
        .assign_op2 (assign_op2),
        .alu_en     (alu_en),
        .entry_disp (entry_disp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] bcd_word(input bit s, input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {s, t, u};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task m_reset();
        stage = 1; val = 0; nd = 0; sg = 0; busy_left = 0;
        m_op = '0; m_opc = '0; m_a1 = 0; m_a2 = 0; m_alu = 0;
    endtask

    task m_step(input logic kv, input logic [3:0] kc);
        m_a1 = 0;
        m_a2 = 0;
        if (kv && kc == KEY_CLR) begin
            m_reset();
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                val = 0; nd = 0; sg = 0;
                if (stage == 3) m_alu = 1;
            end
        end else if (kv) begin
            if (kc <= 4'd9) begin
                if (stage == 3) begin
                    stage = 1; m_alu = 0; val = int'(kc); nd = 1; sg = 0;
                end else if (nd < 2) begin
                    val = val * 10 + int'(kc); nd++;
                end
            end else if (kc == KEY_NEG) begin
                if (stage == 3) begin
                    stage = 1; m_alu = 0; val = 0; nd = 0; sg = 1;
                end else sg = !sg;
            end else if (kc == KEY_ADD || kc == KEY_SUB) begin
                if (stage == 1) begin
                    m_opc = (kc == KEY_ADD) ? 3'b001 : 3'b010;
                    m_op = (nd == 0) ? 9'h000 : bcd_word(sg, val);
                    m_a1 = 1; busy_left = 1 + HOLD; stage = 2;
                end else if (stage == 2 && nd == 0 && !sg) begin
                    m_opc = (kc == KEY_ADD) ? 3'b001 : 3'b010;
                end
            end else if (kc == KEY_EQ && stage == 2) begin
                m_op = (nd == 0) ? 9'h000 : bcd_word(sg, val);
                m_a2 = 1; busy_left = 1 + HOLD; stage = 3;
            end
        end
    endtask

    task automatic check_all();
        logic [8:0] disp;
        disp = (busy_left == 0 && stage != 3) ? bcd_word(sg, val) : 9'h000;
        chk("op", op, m_op);
        chk("opcode", {6'b0, opcode}, {6'b0, m_opc});
        chk("assign_op1", {8'b0, assign_op1}, {8'b0, m_a1});
        chk("assign_op2", {8'b0, assign_op2}, {8'b0, m_a2});
        chk("alu_en", {8'b0, alu_en}, {8'b0, m_alu});
        chk("busy", {8'b0, busy}, {8'b0, busy_left > 0});
        chk("entry_disp", entry_disp, disp);
    endtask

    task automatic tick(input logic kv, input logic [3:0] kc);
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        m_step(kv, kc);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, KEY_NONE);
    endtask

    task automatic press(input logic [3:0] kc);
        tick(1'b1, kc);
        idle(3);
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        nrst = 1'b1;

        // 4,7,ADD,1,2,EQ
        press(4'd4); press(4'd7);
        tick(1'b1, KEY_ADD);
        chk("t1_a1", {8'b0, assign_op1}, 9'h001);
        chk("t1_op1", op, 9'h047);
        chk("t1_opc", {6'b0, opcode}, 9'h001);
        idle(1);
        chk("t1_a1_pulse", {8'b0, assign_op1}, 9'h000);
        idle(2);
        press(4'd1); press(4'd2);
        tick(1'b1, KEY_EQ);
        chk("t1_op2", op, 9'h012);
        chk("t1_a2", {8'b0, assign_op2}, 9'h001);
        idle(HOLD + 1);
        chk("t1_alu_en", {8'b0, alu_en}, 9'h001);

        // NEG,5,SUB,9,EQ from RESULT
        press(KEY_NEG); press(4'd5);
        chk("t2_disp", entry_disp, 9'h105);
        tick(1'b1, KEY_SUB);
        chk("t2_op1", op, 9'h105);
        chk("t2_opc", {6'b0, opcode}, 9'h002);
        idle(3);
        press(4'd9);
        tick(1'b1, KEY_EQ);
        chk("t2_op2", op, 9'h009);
        idle(4);

        // saturation: 1,2,3,ADD
        press(KEY_CLR);
        press(4'd1); press(4'd2); press(4'd3);
        tick(1'b1, KEY_ADD);
        chk("t3_op1", op, 9'h012);
        idle(3);

        // dropped key right after strobe
        press(KEY_CLR); press(4'd3);
        tick(1'b1, KEY_ADD);
        tick(1'b1, 4'd8);
        chk("t4_busy", {8'b0, busy}, 9'h001);
        idle(2);
        chk("t4_disp0", entry_disp, 9'h000);
        tick(1'b1, 4'd8);
        chk("t4_disp8", entry_disp, 9'h008);
        idle(1);

        // CLR during HOLD2
        tick(1'b1, KEY_EQ);
        tick(1'b0, KEY_NONE);
        tick(1'b1, KEY_CLR);
        chk("t5_op", op, 9'h000);
        chk("t5_opc", {6'b0, opcode}, 9'h000);
        chk("t5_alu", {8'b0, alu_en}, 9'h000);
        idle(4);

        // RESULT: ADD/EQ ignored, digit 6 restarts entry
        press(4'd2); press(KEY_ADD); press(4'd3); press(KEY_EQ);
        chk("t6_alu", {8'b0, alu_en}, 9'h001);
        press(KEY_ADD); press(KEY_EQ);
        tick(1'b1, 4'd6);
        chk("t6_alu_drop", {8'b0, alu_en}, 9'h000);
        chk("t6_disp", entry_disp, 9'h006);
        idle(2);

        // asynchronous reset in RESULT
        press(KEY_ADD); press(4'd1); press(KEY_EQ);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("rst_op", op, 9'h000);
        chk("rst_alu", {8'b0, alu_en}, 9'h000);
        chk("rst_opc", {6'b0, opcode}, 9'h000);
        chk("rst_busy", {8'b0, busy}, 9'h000);
        m_reset();
        @(negedge clk);
        key_valid = 1'b0;
        nrst = 1'b1;

        // random keys
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [3:0] kc;
            r = int'($urandom_range(0, 99));
            if (r < 55)      kc = 4'($urandom_range(0, 9));
            else if (r < 65) kc = KEY_ADD;
            else if (r < 72) kc = KEY_SUB;
            else if (r < 82) kc = KEY_EQ;
            else if (r < 89) kc = KEY_NEG;
            else if (r < 91) kc = KEY_CLR;
            else             kc = KEY_NONE;
            tick(1'($urandom_range(0, 1)), kc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_entry_ctrl.md
Name: bcd_entry_ctrl

Overview:
- Keypad-entry stage directly upstream of the BCD ALU.
- Collects up to two BCD digits and a sign per operand, then latches the operator key.
- Presents each operand as a 9-bit sign-magnitude BCD word on op, with a one-cycle assign strobe and a hold window the ALU's two-stage capture needs.
- Raises alu_en once both operands are loaded.

Parameters:
- HOLD_CYCLES, 2, cycles op/opcode stay frozen after an assign strobe before new entry resumes (min 2).

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- key_valid  in  1  one-cycle strobe, key_code valid (already synchronised/debounced)
- key_code  in  4  0-9 digit, A ADD, B SUB, C EQ, D NEG, E CLR, F ignored
- op  out  9  operand to ALU: [8] sign (1=neg), [7:4] tens BCD, [3:0] units BCD
- opcode  out  3  ADD=3'b001, SUB=3'b010
- assign_op1  out  1  one-cycle strobe: op is operand 1
- assign_op2  out  1  one-cycle strobe: op is operand 2
- alu_en  out  1  ALU result valid request, level
- entry_disp  out  9  live entry buffer {sign, tens, units} for display
- busy  out  1  high in LOAD/HOLD states; keys are dropped

Behaviour:
- All outputs are registered.
- Reset values: op=0, opcode=3'b000, assign_op1=0, assign_op2=0, alu_en=0, entry_disp=0, busy=0; state=ENTRY1; digit count=0.
- States: ENTRY1, LOAD1, HOLD1, ENTRY2, LOAD2, HOLD2, RESULT.

Digit entry (ENTRY1/ENTRY2):
- Digit key: buf = {buf[3:0], d}, count++.
- With count==2, further digits are ignored (no wrap, no overflow).
- NEG toggles sign; valid with zero digits.
- key_code 4'hF and undefined keys are ignored everywhere.

ENTRY1 transitions:
- ADD/SUB -> LOAD1; opcode latched.
- Empty buffer loads +00.
- EQ is ignored.

LOAD1 (one cycle):
- op={sign,buf}, assign_op1=1, busy=1.
- Next state is HOLD1.

HOLD1 (HOLD_CYCLES cycles, counter):
- op and opcode frozen, busy=1, assign strobes 0.
- Then go to ENTRY2 with buf, sign and count cleared.

ENTRY2 transitions:
- ADD/SUB with count==0 and sign==0 replaces opcode; otherwise ignored.
- EQ -> LOAD2.

LOAD2 / HOLD2:
- Same as LOAD1/HOLD1, using assign_op2.
- Exit to RESULT with alu_en=1.

RESULT:
- alu_en held at 1; op and opcode hold.
- Digit: alu_en=0, buf/sign cleared, digit entered as first digit, state ENTRY1.
- NEG: alu_en=0, buf cleared, sign=1, state ENTRY1.
- ADD/SUB/EQ are ignored.

CLR:
- Accepted in any state, including LOAD/HOLD.
- Next cycle: state ENTRY1; buf, sign, count, alu_en and assign strobes all 0.
- op and opcode reset to 0.

Dropped keys and timing:
- Keys arriving while busy=1 are dropped (no queue); CLR is the only exception.
- Latency: key accepted at cycle N gives the strobe high during N+1.
- op is valid from N+1 through at least N+1+HOLD_CYCLES.
- entry_disp = {sign,buf} in ENTRY states and 0 otherwise; updates one cycle after the key.

Asynchronous reset mid-operation:
- Immediately drops strobes and alu_en to 0.
- A strobe is never truncated below one full cycle except by reset.

Decomposition:
- Package bcd_calc_pkg holds:
  - key code localparams (KEY_ADD, KEY_SUB, KEY_EQ, KEY_NEG, KEY_CLR, KEY_NONE);
  - opcode localparams (OP_ADD, OP_SUB);
  - state enum entry_state_t.
- Sub-module bcd_digit_buf holds the two-digit shift register, sign, count, and saturation/clear controls; the FSM lives in the top.

Test Plan:
- Keys 4,7,ADD,1,2,EQ, spaced 4 cycles apart:
  - assign_op1 is a 1-cycle pulse with op=9'h047 and opcode=001.
  - assign_op2 is a 1-cycle pulse with op=9'h012.
  - alu_en=1 after HOLD2 completes.
- Keys NEG,5,SUB,9,EQ:
  - op1=9'h105, opcode=010, op2=9'h009.
  - entry_disp shows 9'h105 before SUB.
- Keys 1,2,3,ADD: the third digit is ignored and op1=9'h012.
- Keys 3,ADD, then digit 8 on the cycle right after the strobe:
  - 8 is dropped and busy=1.
  - After HOLD, entry_disp=0.
  - Key 8 entered then gives entry_disp=9'h008.
- CLR mid-operation:
  - CLR during HOLD2: next cycle state ENTRY1, op=0, opcode=0, alu_en=0, no assign_op2 repeat.
  - nrst low while in RESULT: all outputs 0 asynchronously.
- From RESULT, press digit 6:
  - alu_en drops to 0 and entry_disp=9'h006.
  - ADD, EQ in RESULT produce no strobes.
